// File: rtl/instruction_loader_pkg.sv
// -----------------------------------------------------------------------------
// instruction_loader_pkg
// Shared definitions for the program loader and the instruction decoder:
//   OPCODE_HALT    - opcode field value that ends a program
//   loader_state_t - loader FSM encoding (also visible on the debug port)
//   is_halt()      - true when a 6-bit opcode field is the HALT opcode
// -----------------------------------------------------------------------------
package instruction_loader_pkg;

  localparam logic [5:0] OPCODE_HALT = 6'b111111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } loader_state_t;

  function automatic logic is_halt(input logic [5:0] opcode);
    return opcode == OPCODE_HALT;
  endfunction

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Packs a byte stream into big-endian 32-bit words (first byte -> [31:24]).
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_byte          received byte
//   i_valid         byte strobe; a byte is taken on every cycle it is high
//   i_clear         drops any partial word; wins over i_valid
//   o_word          completed word, meaningful only while o_word_ready is high
//   o_word_ready    high in the cycle the 4th byte of a word is presented
// Handshake: i_valid is a pure strobe with no ready; the assembler never
// stalls, so a byte presented with i_valid high (and i_clear low) is consumed.
// o_word/o_word_ready are combinational so the caller can register the word
// in the same cycle the last byte arrives.
// -----------------------------------------------------------------------------
module word_assembler
  import instruction_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  input  logic        i_clear,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (i_clear) begin
      cnt_d   = 2'd0;
      shift_d = 32'h0;
    end else if (i_valid) begin
      shift_d = {shift_q[23:0], i_byte};
      // Wraps 3 -> 0, so the byte after a completed word is byte 0.
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= 2'd0;
      shift_q <= 32'h0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign o_word       = {shift_q[23:0], i_byte};
  assign o_word_ready = i_valid && !i_clear && (cnt_q == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
// Fills instruction memory from the debug UART byte stream. Bytes are packed
// big-endian into 32-bit words which are written to consecutive word
// addresses starting at 0. The load ends after the HALT word is written
// (DONE), or with ERR if the last address is written without a HALT.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start             starts a load from IDLE/DONE/ERR; ignored while busy
//   i_rx_data/valid     byte stream (strobe, no back-pressure)
//   o_mem_we/addr/data  one-cycle memory write
//   o_busy              high in RECV and WRITE
//   o_done              HALT word written
//   o_error             memory filled without HALT
//   o_word_count        words written in the current/last load
//   o_dbg_state         current FSM state (loader_state_t encoding)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic [2:0]            o_dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  asm_valid;
  logic                  asm_clear;
  logic [31:0]           asm_word;
  logic                  asm_word_ready;

  // Bytes are only taken while a load is in progress. In WRITE the byte
  // becomes byte 0 of the next word (the assembler counter has wrapped).
  assign asm_valid = i_rx_valid && (state_q == ST_RECV || state_q == ST_WRITE);

  word_assembler u_word_assembler (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_byte       (i_rx_data),
    .i_valid      (asm_valid),
    .i_clear      (asm_clear),
    .o_word       (asm_word),
    .o_word_ready (asm_word_ready)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    count_d   = count_q;
    asm_clear = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_start) begin
          state_d   = ST_RECV;
          addr_d    = '0;
          count_d   = '0;
          asm_clear = 1'b1;
        end
      end
      ST_RECV: begin
        if (asm_word_ready) begin
          data_d  = asm_word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        count_d = count_q + CNT_ONE;
        if (is_halt(data_q[31:26])) begin
          state_d   = ST_DONE;
          asm_clear = 1'b1;   // a byte arriving now belongs to no word
        end else if (addr_q == '1) begin
          state_d   = ST_ERR;
          asm_clear = 1'b1;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = ST_RECV;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    we_d   = (state_d == ST_WRITE);
    busy_d = (state_d == ST_RECV) || (state_d == ST_WRITE);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= 32'h0;
      count_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_mem_we     = we_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_data   = data_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_error      = err_q;
  assign o_word_count = count_q;
  assign o_dbg_state  = state_q;

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Program loader that fills instruction memory ahead of execution. It takes a byte stream from the debug UART receiver and packs it into 32-bit MIPS instruction words. Each completed word is written to consecutive word addresses of instruction memory. Loading stops after the HALT word (opcode 6'b111111) is written, so the words it produces are exactly those the instruction decoder later consumes.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction memory word-address width (depth = 2^ADDR_WIDTH words)

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle strobe; begins a load (honoured in IDLE, DONE, ERR only)
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe; i_rx_data valid this cycle
- o_mem_we  out  1  instruction memory write enable, one-cycle pulse
- o_mem_addr  out  ADDR_WIDTH  word address for the write
- o_mem_data  out  32  instruction word for the write
- o_busy  out  1  high in RECV and WRITE
- o_done  out  1  high in DONE (HALT word written)
- o_error  out  1  high in ERR (memory filled without HALT)
- o_word_count  out  ADDR_WIDTH+1  words written in current/last load

## Operation
- Byte order is big-endian: the first byte of a word goes to [31:24], the fourth to [7:0].
- States:
  - IDLE: i_rx_valid ignored. i_start -> RECV; clears byte counter, address and o_word_count.
  - RECV: each i_rx_valid byte is shifted in. On the 4th byte, the word is registered into o_mem_data -> WRITE.
  - WRITE: o_mem_we=1 for exactly one cycle at o_mem_addr; o_word_count increments at end of cycle.
    - Registered word [31:26]==6'b111111 -> DONE.
    - Else if o_mem_addr == 2^ADDR_WIDTH-1 -> ERR.
    - Else address+1 -> RECV.
  - DONE / ERR: outputs held; i_rx_valid ignored. i_start -> RECV with counters cleared, as from IDLE.
- A byte arriving in the WRITE cycle is accepted as byte 0 of the next word. It is never dropped. It is discarded only if WRITE exits to DONE or ERR.
- i_start in RECV or WRITE is ignored.
- The HALT word is itself written to memory.
- Address wrap never occurs: the final address either terminates the load (ERR) or holds HALT (DONE).

## Timing
- Reset values: all outputs 0, o_mem_data 32'h0, o_mem_addr 0, state IDLE. The partial word and byte counter are cleared.
- Reset mid-load: immediate return to IDLE. No write pulse follows.
- Latency: 4th byte accepted in cycle N -> o_mem_we high in cycle N+1, with o_mem_addr/o_mem_data stable that cycle.
- o_done / o_error rise in cycle N+2 and stay high until i_start or reset.
- o_busy falls in cycle N+2 on termination.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Minimum supported byte spacing: one byte per cycle.

## Structure
- Shared package:
  - OPCODE_HALT = 6'b111111, also used by the decoder.
  - Loader state encoding: IDLE, RECV, WRITE, DONE, ERR.
- One sub-module, word_assembler: 2-bit byte counter plus 32-bit shift register.
  - Inputs: byte, valid, clear.
  - Outputs: word, word_ready pulse.
- The FSM, address counter and output registers live in instruction_loader.

## Test plan
- i_start, then bytes 20 01 00 05, 20 02 00 07, FC 00 00 00 -> writes (0, 0x20010005), (1, 0x20020007), (2, 0xFC000000); o_done=1, o_word_count=3, o_error=0.
- Back-to-back bytes every cycle, including one byte in the WRITE cycle -> no byte lost; words 0x11223344 and 0x55667788 at addresses 0 and 1.
- ADDR_WIDTH=2, four non-HALT words -> four writes (addr 0..3), then o_error=1, o_word_count=4; further bytes cause no writes.
- i_rst_n low after 2 bytes of a word -> no o_mem_we, outputs zero; after i_start, a full word lands at address 0 with no stale bytes.
- Bytes sent in IDLE, then i_start, then FC 00 00 00 -> only one write (0, 0xFC000000).
- After DONE, i_start, then a new HALT word -> write at address 0; o_done drops on start and rises again; o_word_count=1.
